// File: rtl/sky130_sram_1rw1r_param_if.sv
// Port bundle for the 1RW+1R SRAM: port 0 (read/write), port 1 (read-only),
// clear request and ready status.
interface sky130_sram_1rw1r_param_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WMASK_WIDTH = 8
);
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;

  logic                  clr_req;
  logic                  ready;
  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  dout0_valid;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  dout1_valid;
  logic                  collision;

  modport master (
    output clr_req, csb0, web0, wmask0, addr0, din0, csb1, addr1,
    input  ready, dout0, dout0_valid, dout1, dout1_valid, collision
  );

  modport slave (
    input  clr_req, csb0, web0, wmask0, addr0, din0, csb1, addr1,
    output ready, dout0, dout0_valid, dout1, dout1_valid, collision
  );
endinterface

// File: rtl/sky130_sram_1rw1r_param.sv
// Parametrised 1RW+1R SRAM with byte-lane write mask, clear engine and collision flag.
// Define SRAM_BYPASS_EN to forward port-0 write data to a colliding port-1 read.

// One mask lane of storage: single write port, two asynchronous read taps.
module sky130_sram_lane #(
  parameter int W  = 8,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output logic [W-1:0]  q0,
  output logic [W-1:0]  q1
);
  logic [W-1:0] mem [1<<AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign q0 = mem[raddr0];
`ifdef SRAM_BYPASS_EN
  // Only a port-0 write can coincide with a port-1 read; clear cycles never read.
  assign q1 = (we && waddr == raddr1) ? wdata : mem[raddr1];
`else
  assign q1 = mem[raddr1];
`endif
endmodule

module sky130_sram_1rw1r_param #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WMASK_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  sky130_sram_1rw1r_param_if.slave bus
);
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                                   state;
  logic [ADDR_WIDTH-1:0]                    clr_addr;
  logic [ADDR_WIDTH-1:0]                    waddr;
  logic [NUM_WMASKS-1:0][WMASK_WIDTH-1:0]   q0, q1;
  logic                                     clearing, active, wr0, rd0, rd1;

  // Ports are live only in READY with no clear request pending this cycle.
  assign clearing = rst_n && (state == ST_CLEAR);
  assign active   = rst_n && (state == ST_READY) && !bus.clr_req;
  assign wr0      = active && !bus.csb0 && !bus.web0;
  assign rd0      = active && !bus.csb0 &&  bus.web0;
  assign rd1      = active && !bus.csb1;
  assign waddr    = clearing ? clr_addr : bus.addr0;

  for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_lane
    logic                   lane_we;
    logic [WMASK_WIDTH-1:0] lane_wdata;

    assign lane_we    = clearing || (wr0 && bus.wmask0[g]);
    assign lane_wdata = clearing ? '0 : bus.din0[g*WMASK_WIDTH +: WMASK_WIDTH];

    sky130_sram_lane #(.W(WMASK_WIDTH), .AW(ADDR_WIDTH)) u_lane (
      .clk   (clk),
      .we    (lane_we),
      .waddr (waddr),
      .wdata (lane_wdata),
      .raddr0(bus.addr0),
      .raddr1(bus.addr1),
      .q0    (q0[g]),
      .q1    (q1[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_CLEAR;
      clr_addr        <= '0;
      bus.ready       <= 1'b0;
      bus.dout0       <= '0;
      bus.dout1       <= '0;
      bus.dout0_valid <= 1'b0;
      bus.dout1_valid <= 1'b0;
      bus.collision   <= 1'b0;
    end else begin
      bus.dout0_valid <= rd0;
      bus.dout1_valid <= rd1;
      bus.collision   <= rd1 && wr0 && (bus.addr0 == bus.addr1);
      if (rd0) bus.dout0 <= q0;
      if (rd1) bus.dout1 <= q1;
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr) begin
            state     <= ST_READY;
            bus.ready <= 1'b1;
          end
        end
        ST_READY: begin
          if (bus.clr_req) begin
            state     <= ST_CLEAR;
            clr_addr  <= '0;
            bus.ready <= 1'b0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_sky130_sram_1rw1r_param.sv
// Directed + randomized bench for sky130_sram_1rw1r_param against an array-based reference.
module tb_sky130_sram_1rw1r_param;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int WM    = 8;
  localparam int NL    = DW / WM;
  localparam int DEPTH = 1 << AW;
`ifdef SRAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sky130_sram_1rw1r_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(WM)) bus ();

  sky130_sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(WM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp0, exp1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.clr_req = 1'b0;
    bus.csb0    = 1'b1;
    bus.web0    = 1'b1;
    bus.wmask0  = '0;
    bus.csb1    = 1'b1;
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                          input logic [NL-1:0] m);
    merge = old;
    for (int i = 0; i < NL; i++)
      if (m[i]) merge[i*WM +: WM] = din[i*WM +: WM];
  endfunction

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [NL-1:0] m);
    bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.addr0 = AW'(a); bus.din0 = d; bus.wmask0 = m;
    step();
    idle();
    ref_mem[a] = merge(ref_mem[a], d, m);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check(tag, bus.ready, (i == DEPTH-1));
    end
  endtask

  task automatic zero_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  initial begin
    idle();
    bus.addr0 = '0; bus.addr1 = '0; bus.din0 = '0;
    zero_ref();

    // Reset
    rst_n = 1'b0;
    step(); step();
    check("rst_ready", bus.ready, 0);
    check("rst_dout0", bus.dout0, 0);
    check("rst_dout1", bus.dout1, 0);
    check("rst_v0",    bus.dout0_valid, 0);
    check("rst_v1",    bus.dout1_valid, 0);
    check("rst_col",   bus.collision, 0);
    rst_n = 1'b1;
    wait_ready("init_ready");

    // Test 1: read of cleared address
    bus.csb1 = 1'b0; bus.addr1 = 4'd5;
    step(); idle();
    check("t1_dout1", bus.dout1, 0);
    check("t1_v1",    bus.dout1_valid, 1);
    step();
    check("t1_v1_drop", bus.dout1_valid, 0);

    // Test 2: masked writes
    wr(3, 32'hDEADBEEF, 4'b1111);
    check("t2_no_v0", bus.dout0_valid, 0);
    wr(3, 32'h11223344, 4'b0101);
    bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = 4'd3;
    step(); idle();
    check("t2_dout0", bus.dout0, 32'hDE22BE44);
    check("t2_v0",    bus.dout0_valid, 1);

    // Test 3: collision
    wr(7, 32'hAAAA5555, 4'b1111);
    bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.addr0 = 4'd7; bus.din0 = 32'h12345678; bus.wmask0 = 4'b0011;
    bus.csb1 = 1'b0; bus.addr1 = 4'd7;
    step(); idle();
    ref_mem[7] = merge(ref_mem[7], 32'h12345678, 4'b0011);
    check("t3_col",   bus.collision, 1);
    check("t3_v1",    bus.dout1_valid, 1);
    check("t3_dout1", bus.dout1, BYP ? 32'hAAAA5678 : 32'hAAAA5555);
    exp1 = BYP ? 32'hAAAA5678 : 32'hAAAA5555;
    bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = 4'd7;
    bus.csb1 = 1'b0; bus.addr1 = 4'd7;
    step(); idle();
    check("t3_after0",  bus.dout0, 32'hAAAA5678);
    check("t3_after1",  bus.dout1, 32'hAAAA5678);
    check("t3_rd_nocol", bus.collision, 0);

    // Test 4: clear request; requests during clear are ignored and outputs hold
    wr(12, 32'h0BADCAFE, 4'b1111);
    bus.clr_req = 1'b1; bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.addr0 = 4'd1;
    bus.din0 = 32'hFFFFFFFF; bus.wmask0 = 4'b1111;
    step(); idle();
    check("t4_ready_drop", bus.ready, 0);
    for (int i = 0; i < DEPTH; i++) begin
      bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = 4'd12;
      bus.csb1 = 1'b0; bus.addr1 = 4'd12;
      step();
      check("t4_ready", bus.ready, (i == DEPTH-1));
      check("t4_v0",    bus.dout0_valid, 0);
      check("t4_v1",    bus.dout1_valid, 0);
      check("t4_hold0", bus.dout0, 32'hAAAA5678);
    end
    idle();
    zero_ref();
    for (int a = 0; a < DEPTH; a++) begin
      bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = AW'(a);
      bus.csb1 = 1'b0; bus.addr1 = AW'(DEPTH-1-a);
      step();
      check("t4_zero0", bus.dout0, 0);
      check("t4_zero1", bus.dout1, 0);
    end
    idle();

    // Test 5: reset in the middle of a clear walk
    wr(2, 32'hCAFEF00D, 4'b1111);
    bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = 4'd2;
    bus.csb1 = 1'b0; bus.addr1 = 4'd2;
    step(); idle();
    check("t5_pre0", bus.dout0, 32'hCAFEF00D);
    bus.clr_req = 1'b1;
    step(); idle();
    for (int i = 0; i < 9; i++) step();
    rst_n = 1'b0;
    step();
    check("t5_ready", bus.ready, 0);
    check("t5_dout0", bus.dout0, 0);
    check("t5_dout1", bus.dout1, 0);
    check("t5_v0",    bus.dout0_valid, 0);
    check("t5_col",   bus.collision, 0);
    rst_n = 1'b1;
    wait_ready("t5_ready_rise");
    zero_ref();
    bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = 4'd2;
    bus.csb1 = 1'b0; bus.addr1 = 4'd2;
    step(); idle();
    check("t5_cleared", bus.dout0, 0);
    exp0 = '0;
    exp1 = '0;

    // Randomized traffic on both ports
    for (int n = 0; n < 3000; n++) begin
      logic          c0, w0, c1, w, r0, r1, col;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d;
      logic [NL-1:0] m;
      c0 = ($urandom_range(0, 3) == 0);
      w0 = 1'($urandom_range(0, 1));
      c1 = ($urandom_range(0, 3) == 0);
      a0 = AW'($urandom_range(0, DEPTH-1));
      a1 = ($urandom_range(0, 2) == 0) ? a0 : AW'($urandom_range(0, DEPTH-1));
      d  = $urandom;
      m  = NL'($urandom);
      bus.csb0 = c0; bus.web0 = w0; bus.addr0 = a0; bus.din0 = d; bus.wmask0 = m;
      bus.csb1 = c1; bus.addr1 = a1;
      w   = !c0 && !w0;
      r0  = !c0 && w0;
      r1  = !c1;
      col = w && r1 && (a0 == a1);
      if (r0) exp0 = ref_mem[a0];
      if (r1) exp1 = (col && BYP) ? merge(ref_mem[a1], d, m) : ref_mem[a1];
      if (w)  ref_mem[a0] = merge(ref_mem[a0], d, m);
      step();
      check("rnd_v0",    bus.dout0_valid, r0);
      check("rnd_v1",    bus.dout1_valid, r1);
      check("rnd_col",   bus.collision, col);
      check("rnd_dout0", bus.dout0, exp0);
      check("rnd_dout1", bus.dout1, exp1);
    end
    idle();
    step();
    check("end_ready", bus.ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
